// File: rtl/msx_io_pkg.sv
// Shared definitions for the MSX Z80-timed I/O cycle master.
// Bus states, well-known peripheral ports and wait-state limits.
package msx_io_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4
  } io_state_e;

  localparam logic [7:0] PORT_VDP = 8'h98;
  localparam logic [7:0] PORT_PSG = 8'hA0;
  localparam logic [7:0] PORT_PPI = 8'hA8;
  localparam logic [7:0] PORT_CEN = 8'h90;

  localparam int AUTO_WAIT_MAX = 7;

endpackage

// File: rtl/io_cycle_master.sv
// Z80 I/O machine cycle initiator: valid/ready request in, T1/T2/TW/T3 strobes out.
// Ports: clk, reset_n, ce, req_*, rsp_*, addr/dout/din, iorq_n/rd_n/wr_n/m1_n, wait_n.
// Option IO_CYCLE_TIMEOUT_EN adds a wait_n timeout (TIMEOUT_CE) that aborts with rsp_error.
module io_cycle_master
  import msx_io_pkg::*;
#(
  parameter int AUTO_WAIT = 1
`ifdef IO_CYCLE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CE = 255
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic [7:0] addr,
  output logic [7:0] dout,
  input  logic [7:0] din,
  output logic       iorq_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       m1_n,
  input  logic       wait_n
);

  localparam logic [2:0] AW_LOAD =
    (AUTO_WAIT > 0) ? 3'(AUTO_WAIT - 1) : 3'd0;

  io_state_e  state_q, state_d;
  logic       pend_q;
  logic       wr_q;
  logic [7:0] a_q, d_q;
  logic [2:0] wcnt_q;
  logic       done, abort, strobe_d, last_tw;

  assign m1_n      = 1'b1;
  assign req_ready = (state_q == IDLE) && !pend_q;
  assign last_tw   = (state_q == TW) && ce && (wcnt_q == 3'd0);
  assign strobe_d  = (state_d == T2) || (state_d == TW)
                  || (state_d == T3);

`ifdef IO_CYCLE_TIMEOUT_EN
  localparam logic [7:0] TO_M1 = 8'(TIMEOUT_CE - 1);
  logic [7:0] tcnt_q;
`endif

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: if (ce && pend_q) state_d = T1;
      T1:   if (ce) state_d = T2;
      T2:   if (ce) state_d = (AUTO_WAIT > 0) ? TW : T3;
      TW: begin
        if (last_tw) begin
          if (wait_n) begin
            state_d = T3;
`ifdef IO_CYCLE_TIMEOUT_EN
          end else if (tcnt_q == TO_M1) begin
            state_d = IDLE;
            abort   = 1'b1;
`endif
          end
        end
      end
      T3: begin
        if (ce) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      wr_q      <= 1'b0;
      a_q       <= 8'h00;
      d_q       <= 8'h00;
      wcnt_q    <= 3'd0;
      addr      <= 8'h00;
      dout      <= 8'h00;
      iorq_n    <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      state_q   <= state_d;
      rsp_valid <= done | abort;
      // Strobes are registered from next state so they change on the ce edge.
      iorq_n    <= !strobe_d;
      rd_n      <= !(strobe_d && !wr_q);
      wr_n      <= !(strobe_d && wr_q);
      if (req_valid && req_ready) begin
        pend_q <= 1'b1;
        wr_q   <= req_write;
        a_q    <= req_addr;
        d_q    <= req_wdata;
      end
      if (state_q == IDLE && state_d == T1) begin
        pend_q <= 1'b0;
        addr   <= a_q;
        if (wr_q) dout <= d_q;
      end
      if (state_q == T2 && state_d == TW) begin
        wcnt_q <= AW_LOAD;
      end else if (state_q == TW && ce && wcnt_q != 3'd0) begin
        wcnt_q <= wcnt_q - 3'd1;
      end
      if (done && !wr_q) rsp_rdata <= din;
      if (abort && !wr_q) rsp_rdata <= 8'hFF;
    end
  end

`ifdef IO_CYCLE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q    <= 8'h00;
      rsp_error <= 1'b0;
    end else begin
      rsp_error <= abort;
      if (state_d == T1) tcnt_q <= 8'h00;
      else if (last_tw && !wait_n) tcnt_q <= tcnt_q + 8'h01;
    end
  end
`else
  assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_io_cycle_master.sv
// Directed bench for io_cycle_master: OUT/IN cycles, wait states,
// back-to-back requests and async reset mid-cycle.
module tb_io_cycle_master;
  import msx_io_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       ce;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic [7:0] addr;
  logic [7:0] dout;
  logic [7:0] din;
  logic       iorq_n, rd_n, wr_n, m1_n;
  logic       wait_n;

  int n_cmp = 0;
  int n_bad = 0;

  int ce_ticks = 0;
  int wr_lo = 0, rd_lo = 0, io_lo = 0, both_lo = 0;
  int io_rises = 0;
  int rsp_cnt = 0;
  int rsp_tick = 0;
  int acc_ticks = 0;
  logic prev_iorq = 1'b1;
  logic [7:0] last_rdata;
  logic last_err;

  io_cycle_master #(
    .AUTO_WAIT(1)
`ifdef IO_CYCLE_TIMEOUT_EN
    ,
    .TIMEOUT_CE(4)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ce(ce),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .addr(addr),
    .dout(dout),
    .din(din),
    .iorq_n(iorq_n),
    .rd_n(rd_n),
    .wr_n(wr_n),
    .m1_n(m1_n),
    .wait_n(wait_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ce every other clock; counts T-states with each strobe low.
  initial begin
    ce = 1'b0;
    last_rdata = 8'h00;
    last_err = 1'b0;
    forever begin
      @(negedge clk);
      if (ce) begin
        ce_ticks++;
        if (!wr_n) wr_lo++;
        if (!rd_n) rd_lo++;
        if (!iorq_n) io_lo++;
      end
      if (!rd_n && !wr_n) both_lo++;
      if (!prev_iorq && iorq_n) io_rises++;
      prev_iorq = iorq_n;
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_tick = ce_ticks;
        last_rdata = rsp_rdata;
        last_err = rsp_error;
      end
      ce = ~ce;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    wr_lo = 0; rd_lo = 0; io_lo = 0;
    both_lo = 0; io_rises = 0;
  endtask

  task automatic send(input logic w, input logic [7:0] a,
                      input logic [7:0] d);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    acc_ticks = ce_ticks + (ce ? 1 : 0);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n0, input string tag);
    int n;
    n = 0;
    while (rsp_cnt == n0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, rsp_cnt, n0 + 1);
  endtask

  task automatic wait_ticks(input int k);
    int n;
    n = 0;
    while ((ce_ticks - acc_ticks) < k && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int r0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    din       = 8'h00;
    wait_n    = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_iorq", {31'd0, iorq_n}, 32'd1);
    chk("rst_rd", {31'd0, rd_n}, 32'd1);
    chk("rst_wr", {31'd0, wr_n}, 32'd1);
    chk("rst_m1", {31'd0, m1_n}, 32'd1);
    chk("rst_addr", {24'd0, addr}, 32'h00);
    chk("rst_dout", {24'd0, dout}, 32'h00);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'h00);
    chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rst_err", {31'd0, rsp_error}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    // OUT 0x98 <- 0x5A
    clr_stats();
    r0 = rsp_cnt;
    send(1'b1, PORT_VDP, 8'h5A);
    chk("out_busy", {31'd0, req_ready}, 32'd0);
    wait_rsp(r0, "out_rsp");
    repeat (4) @(posedge clk); #1;
    chk("out_pulse", rsp_cnt, r0 + 1);
    chk("out_wr_lo", wr_lo, 3);
    chk("out_io_lo", io_lo, 3);
    chk("out_rd_lo", rd_lo, 0);
    chk("out_lat", rsp_tick - acc_ticks, 5);
    chk("out_addr", {24'd0, addr}, 32'h98);
    chk("out_dout", {24'd0, dout}, 32'h5A);
    chk("out_err", {31'd0, last_err}, 32'd0);
    chk("out_rdata", {24'd0, last_rdata}, 32'h00);

    // IN 0xA8, din = 0x3C
    clr_stats();
    din = 8'h3C;
    r0 = rsp_cnt;
    send(1'b0, PORT_PPI, 8'hEE);
    wait_rsp(r0, "in_rsp");
    chk("in_rd_lo", rd_lo, 3);
    chk("in_wr_lo", wr_lo, 0);
    chk("in_lat", rsp_tick - acc_ticks, 5);
    chk("in_rdata", {24'd0, last_rdata}, 32'h3C);
    chk("in_err", {31'd0, last_err}, 32'd0);
    chk("in_addr", {24'd0, addr}, 32'hA8);
    chk("in_dout", {24'd0, dout}, 32'h5A);

    // IN 0xA0 with three extra waits
    clr_stats();
    din = 8'h77;
    wait_n = 1'b0;
    r0 = rsp_cnt;
    send(1'b0, PORT_PSG, 8'h00);
    wait_ticks(6);
    wait_n = 1'b1;
    wait_rsp(r0, "wt_rsp");
    chk("wt_rd_lo", rd_lo, 6);
    chk("wt_io_lo", io_lo, 6);
    chk("wt_lat", rsp_tick - acc_ticks, 8);
    chk("wt_rdata", {24'd0, last_rdata}, 32'h77);

    // back-to-back OUTs
    clr_stats();
    r0 = rsp_cnt;
    send(1'b1, 8'h99, 8'h01);
    chk("b2b_busy", {31'd0, req_ready}, 32'd0);
    wait_rsp(r0, "b2b_rsp1");
    chk("b2b_dout1", {24'd0, dout}, 32'h01);
    send(1'b1, 8'h99, 8'h80);
    wait_rsp(r0 + 1, "b2b_rsp2");
    chk("b2b_dout2", {24'd0, dout}, 32'h80);
    chk("b2b_wr_lo", wr_lo, 6);
    chk("b2b_rises", io_rises, 2);
    chk("b2b_rdata", {24'd0, rsp_rdata}, 32'h77);
    chk("b2b_both", both_lo, 0);

    // async reset during T2
    r0 = rsp_cnt;
    send(1'b1, PORT_CEN, 8'h11);
    wait_ticks(2);
    chk("rst_t2_io", {31'd0, iorq_n}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_iorq", {31'd0, iorq_n}, 32'd1);
    chk("arst_wr", {31'd0, wr_n}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    repeat (12) @(posedge clk); #1;
    chk("arst_norsp", rsp_cnt, r0);
    chk("arst_addr", {24'd0, addr}, 32'h00);
    chk("arst_iorq2", {31'd0, iorq_n}, 32'd1);

`ifdef IO_CYCLE_TIMEOUT_EN
    wait_n = 1'b0;
    din = 8'h12;
    r0 = rsp_cnt;
    send(1'b0, PORT_PSG, 8'h00);
    wait_rsp(r0, "to_rsp");
    chk("to_err", {31'd0, last_err}, 32'd1);
    chk("to_rdata", {24'd0, last_rdata}, 32'hFF);
    chk("to_lat", rsp_tick - acc_ticks, 7);
    wait_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
